// File: rtl/stream_pkg.sv
// Shared definitions for the valid/ready stream blocks (adder FIFO, crossbar, ...).
package stream_pkg;

    localparam int STREAM_DATA_W = 32;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage for stream FIFOs: one synchronous write port, one
// asynchronous read port. The array is deliberately not reset.
module fifo_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: capture the word only on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/adder_resp_fifo.sv
// Response FIFO between the Adder result stream and the Wishbone result-return
// path; exposes occupancy and a synchronous flush to the host control path.
module adder_resp_fifo
    import stream_pkg::*;
#(
    parameter  int DATA_W = STREAM_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_stream_val,
    input  logic [DATA_W-1:0] i_stream_data,
    output logic              i_stream_rdy,
    output logic              o_stream_val,
    output logic [DATA_W-1:0] o_stream_data,
    input  logic              o_stream_rdy,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;

    // Both handshakes are suppressed during flush so neither side sees a transfer
    assign i_stream_rdy  = !flush && (count_q != CNT_MAX);
    assign o_stream_val  = !flush && (count_q != {CNT_W{1'b0}});
    assign push_s        = i_stream_val && i_stream_rdy;
    assign pop_s         = o_stream_val && o_stream_rdy;
    assign o_stream_data = (count_q != {CNT_W{1'b0}}) ? head_s : {DATA_W{1'b0}};
    assign count         = count_q;

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (i_stream_data),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Next-state for pointers and occupancy; flush overrides any handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_adder_resp_fifo.sv
// Directed bench for adder_resp_fifo with a queue scoreboard of expected words.
module tb_adder_resp_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              i_stream_val;
    logic [DATA_W-1:0] i_stream_data;
    logic              i_stream_rdy;
    logic              o_stream_val;
    logic [DATA_W-1:0] o_stream_data;
    logic              o_stream_rdy;
    logic [CNT_W-1:0]  count;

    int total;
    int bad;
    int pops;
    logic [DATA_W-1:0] exp_q [$];

    adder_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .i_stream_val  (i_stream_val),
        .i_stream_data (i_stream_data),
        .i_stream_rdy  (i_stream_rdy),
        .o_stream_val  (o_stream_val),
        .o_stream_data (o_stream_data),
        .o_stream_rdy  (o_stream_rdy),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard the handshakes at mid-cycle, then advance to just after the next edge
    task automatic tick();
        logic [DATA_W-1:0] e;
        @(negedge clk);
        if (reset && flush) begin
            exp_q.delete();
        end else if (reset) begin
            if (o_stream_val && o_stream_rdy) begin
                check("pop_has_exp", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pop_data", o_stream_data, e);
                    pops++;
                end
            end
            if (i_stream_val && i_stream_rdy) begin
                exp_q.push_back(i_stream_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        i_stream_val  = 1'b1;
        i_stream_data = d;
        tick();
        i_stream_val  = 1'b0;
    endtask

    task automatic drain(input int n);
        o_stream_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("drain_val", 32'(o_stream_val), 32'd1);
            tick();
        end
        o_stream_rdy = 1'b0;
        #1;
        check("drain_empty_cnt", 32'(count), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        pops  = 0;
        reset = 1'b0;
        flush = 1'b0;
        i_stream_val  = 1'b0;
        i_stream_data = 32'h0;
        o_stream_rdy  = 1'b0;

        // 1: reset then idle
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick();
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_oval", 32'(o_stream_val), 32'd0);
        check("rst_irdy", 32'(i_stream_rdy), 32'd1);
        check("rst_odata", o_stream_data, 32'h0);

        // 2: three words buffered then drained in order
        push(32'h0000_0011);
        #1;
        check("t2_latency_val", 32'(o_stream_val), 32'd1);
        check("t2_head", o_stream_data, 32'h0000_0011);
        push(32'h0000_0022);
        push(32'h0000_0033);
        #1;
        check("t2_count3", 32'(count), 32'd3);
        drain(3);
        check("t2_pops", 32'(pops), 32'd3);

        // 3: fill, stall a 5th word, pop one, then accept it
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        #1;
        check("t3_full_cnt", 32'(count), 32'd4);
        check("t3_full_rdy", 32'(i_stream_rdy), 32'd0);
        i_stream_val  = 1'b1;
        i_stream_data = 32'hA4;
        tick();
        check("t3_stall_cnt", 32'(count), 32'd4);
        o_stream_rdy = 1'b1;
        #1;
        check("t3_pop_rdy_low", 32'(i_stream_rdy), 32'd0);
        tick();
        o_stream_rdy = 1'b0;
        #1;
        check("t3_rdy_rise", 32'(i_stream_rdy), 32'd1);
        check("t3_cnt3", 32'(count), 32'd3);
        check("t3_head_a1", o_stream_data, 32'hA1);
        tick();
        i_stream_val = 1'b0;
        #1;
        check("t3_cnt4", 32'(count), 32'd4);
        drain(4);

        // 4: steady state at count=2, push and pop every cycle
        push(32'h100);
        push(32'h101);
        i_stream_val = 1'b1;
        o_stream_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            i_stream_data = 32'(k);
            #1;
            check("t4_val", 32'(o_stream_val), 32'd1);
            check("t4_cnt", 32'(count), 32'd2);
            tick();
        end
        i_stream_val = 1'b0;
        o_stream_rdy = 1'b0;
        #1;
        check("t4_head", o_stream_data, 32'd9);
        drain(2);

        // 5: flush with both handshakes attempted
        push(32'h51);
        push(32'h52);
        push(32'h53);
        flush = 1'b1;
        i_stream_val  = 1'b1;
        i_stream_data = 32'h99;
        o_stream_rdy  = 1'b1;
        #1;
        check("t5_flush_irdy", 32'(i_stream_rdy), 32'd0);
        check("t5_flush_oval", 32'(o_stream_val), 32'd0);
        tick();
        flush = 1'b0;
        i_stream_val = 1'b0;
        o_stream_rdy = 1'b0;
        #1;
        check("t5_cnt0", 32'(count), 32'd0);
        check("t5_oval0", 32'(o_stream_val), 32'd0);
        push(32'h55);
        #1;
        check("t5_head", o_stream_data, 32'h55);
        drain(1);

        // 6: asynchronous reset mid-cycle
        push(32'h61);
        push(32'h62);
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_oval", 32'(o_stream_val), 32'd0);
        check("t6_async_cnt", 32'(count), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        push(32'h77);
        #1;
        check("t6_head", o_stream_data, 32'h77);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
